// File: rtl/core_pkg.sv
// Shared definitions for the single-cycle core and its run/step sequencer.
// The run-state encoding is visible on the STATE output, so it must stay fixed.
package core_pkg;

   typedef enum logic [1:0] {
      RS_IDLE = 2'b00,
      RS_RUN  = 2'b01,
      RS_STEP = 2'b10,
      RS_HALT = 2'b11
   } run_state_t;

   // Opcode of the halt (J) instruction, decoded by the core into HALT_REQ.
   localparam logic [5:0] OP_J = 6'b000010;

endpackage

// File: rtl/sw_debounce.sv
// Board switch conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on each accepted rising level.
module sw_debounce
   import core_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic press
);

   localparam int CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic                sync_meta;
   logic                sync_out;
   logic [1:0]          sync_fill;
   logic [CNT_BITS-1:0] stable_cnt;
   logic                level_q;
   logic                level_d;
   logic                armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
         sync_fill <= 2'b00;
      end else begin
         sync_meta <= sw;
         sync_out  <= sync_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_cnt <= '0;
         level_q    <= 1'b0;
      end else if (sync_out == level_q) begin
         stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
         level_q    <= sync_out;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + CNT_BITS'(1);
      end
   end

   // A switch held through reset must be seen released before it can press;
   // sync_fill keeps the reset-cleared synchronizer from faking that release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= 1'b0;
         armed   <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level_q;
         armed   <= armed | (sync_fill[1] & ~sync_out);
         press   <= armed & level_q & ~level_d;
      end
   end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step sequencer for the single-cycle core: switch commands, PC breakpoint,
// halt handling and the retired-instruction counter.
module core_run_ctrl
   import core_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int PC_W            = 32,
   parameter int CNT_W           = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SW_W,
   input  logic             SW_E,
   input  logic [PC_W-1:0]  PC,
   input  logic             HALT_REQ,
   input  logic             BP_EN,
   input  logic [PC_W-1:0]  BP_ADDR,
   output logic             CORE_EN,
   output logic             CORE_CLR,
   output logic [1:0]       STATE,
   output logic [CNT_W-1:0] INSTR_CNT
);

   run_state_t state_q;
   run_state_t state_d;
   logic       bp_skip;
   logic       bp_hit;
   logic       clr_d;
   logic       w_press;
   logic       e_press;

   sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_w (
      .clk   (CLK),
      .rst_n (RST_N),
      .sw    (SW_W),
      .press (w_press)
   );

   sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_e (
      .clk   (CLK),
      .rst_n (RST_N),
      .sw    (SW_E),
      .press (e_press)
   );

   // CORE_EN stays combinational so a breakpoint blocks the matching PC with no latency.
   always_comb begin
      state_d = state_q;
      CORE_EN = 1'b0;
      clr_d   = 1'b0;
      bp_hit  = BP_EN && (PC == BP_ADDR) && !bp_skip;
      case (state_q)
         RS_IDLE: begin
            if (w_press)
               state_d = RS_RUN;
            else if (e_press)
               state_d = RS_STEP;
         end
         RS_RUN: begin
            if (bp_hit) begin
               state_d = RS_IDLE;
            end else begin
               CORE_EN = 1'b1;
               if (HALT_REQ)
                  state_d = RS_HALT;
               else if (e_press)
                  state_d = RS_IDLE;
            end
         end
         RS_STEP: begin
            CORE_EN = 1'b1;
            state_d = HALT_REQ ? RS_HALT : RS_IDLE;
         end
         RS_HALT: begin
            if (w_press) begin
               state_d = RS_IDLE;
               clr_d   = 1'b1;
            end
         end
         default: state_d = RS_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= RS_IDLE;
         CORE_CLR  <= 1'b0;
         bp_skip   <= 1'b0;
         INSTR_CNT <= '0;
      end else begin
         state_q  <= state_d;
         CORE_CLR <= clr_d;
         if (clr_d)
            bp_skip <= 1'b0;
         else if (state_q == RS_RUN && bp_hit)
            bp_skip <= 1'b1;
         else if (CORE_EN)
            bp_skip <= 1'b0;
         if (clr_d)
            INSTR_CNT <= '0;
         else if (CORE_EN)
            INSTR_CNT <= INSTR_CNT + CNT_W'(1);
      end
   end

   assign STATE = state_q;

endmodule
